// File: rtl/pipe_pkg.sv
// Shared definitions for the ID/EX skid-buffered stage register:
// control-bit positions, default side-effect mask, payload sizing.
package pipe_pkg;

    localparam int CTRL_MEMWRITE = 0;
    localparam int CTRL_REGWRITE = 1;
    localparam int CTRL_MEMTOREG = 2;
    localparam int CTRL_ALUSRC   = 3;
    localparam int CTRL_ALUOP_LO = 4;
    localparam int CTRL_ALUOP_HI = 7;
    localparam int CTRL_LLB      = 8;
    localparam int CTRL_LHB      = 9;

    localparam logic [15:0] SE_MASK_DEF =
        (16'h1 << CTRL_MEMWRITE) | (16'h1 << CTRL_REGWRITE);

    function automatic int payload_w(int dw, int n, int cw);
        return dw * (1 + n) + cw + 1;
    endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready bundle carrying one stage-register entry:
// PC, packed operand channels, control vector and noop flag.
interface pipe_stage_skid_if #(
    parameter int DATA_W   = 16,
    parameter int NUM_OPND = 3,
    parameter int CTRL_W   = 16
);
    logic                       valid;
    logic                       ready;
    logic [DATA_W-1:0]          pc;
    logic [NUM_OPND*DATA_W-1:0] opnd;
    logic [CTRL_W-1:0]          ctrl;
    logic                       noop;

    modport master (
        output valid, pc, opnd, ctrl, noop,
        input  ready
    );

    modport slave (
        input  valid, pc, opnd, ctrl, noop,
        output ready
    );
endinterface

// File: rtl/pipe_slot.sv
// One storage slot: a valid flop plus a load-enabled payload
// register, both cleared by the asynchronous active-low reset.
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_i,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);
    logic         valid_q;
    logic [W-1:0] data_q;

    // valid bit follows its next-state every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) valid_q <= 1'b0;
        else        valid_q <= valid_i;
    end

    // payload only changes when a new entry is written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      data_q <= '0;
        else if (load_i) data_q <= data_i;
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
endmodule

// File: rtl/pipe_stage_skid.sv
// ID/EX stage register with a 2-entry skid buffer (main M + skid S),
// flush, side-effect masking on bubbles and saturating perf counters.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                NUM_OPND = 3,
    parameter int                CTRL_W   = 16,
    parameter logic [CTRL_W-1:0] SE_MASK  = CTRL_W'(SE_MASK_DEF),
    parameter int                CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    pipe_stage_skid_if.slave      in_if,
    pipe_stage_skid_if.master     out_if,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      bubble_cnt
);
    localparam int PW = payload_w(DATA_W, NUM_OPND, CTRL_W);
    localparam int OW = NUM_OPND * DATA_W;

    logic          acc;
    logic          cons;
    logic          m_vld_q;
    logic          s_vld_q;
    logic          m_vld_d;
    logic          s_vld_d;
    logic          m_ld;
    logic          s_ld;
    logic [PW-1:0] in_pay;
    logic [PW-1:0] m_pay_d;
    logic [PW-1:0] m_pay_q;
    logic [PW-1:0] s_pay_q;
    logic [CTRL_W-1:0] m_ctrl;
    logic          m_noop;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] stall_d;
    logic [CNT_W-1:0] bubble_q;
    logic [CNT_W-1:0] bubble_d;

    assign in_pay = {in_if.pc, in_if.opnd, in_if.ctrl, in_if.noop};

    // ready comes straight from the skid valid flop
    assign in_if.ready = ~s_vld_q;
    assign acc  = in_if.valid & ~s_vld_q;
    assign cons = m_vld_q & out_if.ready;

    // slot next-state: flush, fill/pass-through, drain skid, park in skid
    always_comb begin
        m_vld_d = m_vld_q;
        s_vld_d = s_vld_q;
        m_ld    = 1'b0;
        s_ld    = 1'b0;
        m_pay_d = in_pay;
        if (flush) begin
            m_vld_d = 1'b0;
            s_vld_d = 1'b0;
        end else if (!m_vld_q || (cons && !s_vld_q)) begin
            m_vld_d = acc;
            m_ld    = acc;
        end else if (cons) begin
            m_vld_d = 1'b1;
            m_ld    = 1'b1;
            m_pay_d = s_pay_q;
            s_vld_d = 1'b0;
        end else if (acc) begin
            s_vld_d = 1'b1;
            s_ld    = 1'b1;
        end
    end

    pipe_slot #(.W(PW)) u_m (
        .clk     (clk),
        .rst_n   (rst),
        .valid_i (m_vld_d),
        .load_i  (m_ld),
        .data_i  (m_pay_d),
        .valid_o (m_vld_q),
        .data_o  (m_pay_q)
    );

    pipe_slot #(.W(PW)) u_s (
        .clk     (clk),
        .rst_n   (rst),
        .valid_i (s_vld_d),
        .load_i  (s_ld),
        .data_i  (in_pay),
        .valid_o (s_vld_q),
        .data_o  (s_pay_q)
    );

    assign m_ctrl = m_pay_q[1 +: CTRL_W];
    assign m_noop = m_pay_q[0];

    assign out_if.valid = m_vld_q;
    assign out_if.pc    = m_pay_q[PW-1 -: DATA_W];
    assign out_if.opnd  = m_pay_q[CTRL_W+1 +: OW];
    assign out_if.noop  = m_noop;
    assign out_if.ctrl  = (!m_vld_q || m_noop) ? (m_ctrl & ~SE_MASK)
                                               : m_ctrl;

    // saturating counters; flush cycles are not sampled
    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        if (!flush) begin
            if (m_vld_q && !out_if.ready && stall_q != '1)
                stall_d = stall_q + 1'b1;
            if (!m_vld_q && out_if.ready && bubble_q != '1)
                bubble_d = bubble_q + 1'b1;
        end
    end

    // counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: driver pushes expected
// entries on accept, monitor pops and compares on each consume.
module tb_pipe_stage_skid;
    localparam int DW = 16;
    localparam int NO = 3;
    localparam int CW = 16;
    localparam int CN = 4;

    typedef struct {
        logic [DW-1:0]    pc;
        logic [NO*DW-1:0] opnd;
        logic [CW-1:0]    ctrl;
        logic             noop;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    logic [CN-1:0] stall_cnt;
    logic [CN-1:0] bubble_cnt;

    int checks = 0;
    int fails  = 0;
    exp_t q[$];

    pipe_stage_skid_if #(.DATA_W(DW), .NUM_OPND(NO), .CTRL_W(CW)) in_if();
    pipe_stage_skid_if #(.DATA_W(DW), .NUM_OPND(NO), .CTRL_W(CW)) out_if();

    pipe_stage_skid #(
        .DATA_W(DW), .NUM_OPND(NO), .CTRL_W(CW), .CNT_W(CN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_if      (in_if),
        .out_if     (out_if),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [NO*DW-1:0] mk_opnd(logic [DW-1:0] pc);
        return {pc ^ 16'hA5A5, pc + 16'h0001, ~pc};
    endfunction

    // monitor: every consumed entry must match the oldest expected one
    always @(negedge clk) begin
        if (rst && out_if.valid && out_if.ready) begin
            if (q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_out actual=%h required=none",
                         out_if.pc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_pc", 64'(out_if.pc), 64'(e.pc));
                chk("out_opnd", 64'(out_if.opnd), 64'(e.opnd));
                chk("out_ctrl", 64'(out_if.ctrl), 64'(e.ctrl));
                chk("out_noop", 64'(out_if.noop), 64'(e.noop));
            end
        end
    end

    task automatic send(logic [DW-1:0] pc, logic [CW-1:0] ctrl,
                        logic noop, logic [CW-1:0] exp_ctrl);
        bit done = 0;
        int n = 0;
        exp_t e;
        in_if.valid = 1'b1;
        in_if.pc    = pc;
        in_if.opnd  = mk_opnd(pc);
        in_if.ctrl  = ctrl;
        in_if.noop  = noop;
        while (!done) begin
            @(negedge clk);
            if (in_if.ready) begin
                e.pc = pc;
                e.opnd = mk_opnd(pc);
                e.ctrl = exp_ctrl;
                e.noop = noop;
                q.push_back(e);
                done = 1;
            end else if (n > 50) begin
                checks++;
                fails++;
                $display("FAIL send_timeout actual=blocked required=ready");
                done = 1;
            end
            n++;
            @(posedge clk);
            #1;
        end
        in_if.valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        in_if.valid = 1'b0;
        in_if.pc    = '0;
        in_if.opnd  = '0;
        in_if.ctrl  = '0;
        in_if.noop  = 1'b0;
        out_if.ready = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_if.valid), 64'd0);
        chk("rst_in_ready", 64'(in_if.ready), 64'd1);
        chk("rst_out_ctrl", 64'(out_if.ctrl), 64'd0);
        chk("rst_out_pc", 64'(out_if.pc), 64'd0);
        chk("rst_out_noop", 64'(out_if.noop), 64'd0);
        chk("rst_stall", 64'(stall_cnt), 64'd0);
        chk("rst_bubble", 64'(bubble_cnt), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // stream of four entries at full rate
        out_if.ready = 1'b1;
        send(16'h0000, 16'h0012, 1'b0, 16'h0012);
        chk("stream_first_valid", 64'(out_if.valid), 64'd1);
        send(16'h0002, 16'h0012, 1'b0, 16'h0012);
        send(16'h0004, 16'h0012, 1'b0, 16'h0012);
        send(16'h0006, 16'h0012, 1'b0, 16'h0012);
        repeat (3) @(posedge clk);
        #1;
        chk("stream_stall", 64'(stall_cnt), 64'd0);
        chk("stream_drained", 64'(q.size()), 64'd0);

        // backpressure into the skid slot
        do_reset();
        out_if.ready = 1'b0;
        send(16'h0010, 16'h0012, 1'b0, 16'h0012);
        send(16'h0012, 16'h0012, 1'b0, 16'h0012);
        @(negedge clk);
        chk("skid_in_ready", 64'(in_if.ready), 64'd0);
        @(posedge clk);
        #1 out_if.ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("skid_ready_back", 64'(in_if.ready), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("skid_stall_cnt", 64'(stall_cnt), 64'd2);
        chk("skid_drained", 64'(q.size()), 64'd0);

        // noop masking, then bubble masking of held entry
        send(16'h0020, 16'h0033, 1'b1, 16'h0030);
        send(16'h0022, 16'h0033, 1'b0, 16'h0033);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("bubble_valid", 64'(out_if.valid), 64'd0);
        chk("bubble_ctrl", 64'(out_if.ctrl), 64'h0030);
        @(posedge clk);
        #1;

        // flush with both slots full and a new offer
        out_if.ready = 1'b0;
        send(16'h0030, 16'h0003, 1'b0, 16'h0003);
        send(16'h0032, 16'h0003, 1'b0, 16'h0003);
        flush = 1'b1;
        in_if.valid = 1'b1;
        in_if.pc = 16'h0034;
        in_if.opnd = mk_opnd(16'h0034);
        in_if.ctrl = 16'h0003;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_if.valid = 1'b0;
        q.delete();
        @(negedge clk);
        chk("flush_out_valid", 64'(out_if.valid), 64'd0);
        chk("flush_in_ready", 64'(in_if.ready), 64'd1);
        chk("flush_se_bits", 64'(out_if.ctrl & 16'h0003), 64'd0);
        @(posedge clk);
        #1 out_if.ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // bubble counter saturation
        do_reset();
        out_if.ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("bubble_sat", 64'(bubble_cnt), 64'hF);
        chk("bubble_sat_stall", 64'(stall_cnt), 64'd0);

        // asynchronous reset while stalled with both slots full
        out_if.ready = 1'b0;
        send(16'h0040, 16'h0012, 1'b0, 16'h0012);
        send(16'h0042, 16'h0012, 1'b0, 16'h0012);
        #2 rst = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_if.valid), 64'd0);
        chk("arst_in_ready", 64'(in_if.ready), 64'd1);
        chk("arst_stall", 64'(stall_cnt), 64'd0);
        chk("arst_bubble", 64'(bubble_cnt), 64'd0);
        q.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-width ID/EX stage register.
- Carries PC, N operand channels, a control vector and a noop flag between two pipeline stages.
- Uses a valid/ready handshake with a 2-entry skid buffer, so backpressure is not combinationally propagated.
- Adds synchronous flush, bubble masking of side-effect control bits, and saturating stall/bubble performance counters.

Parameters:
- DATA_W, 16, width of PC and of each operand channel
- NUM_OPND, 3, number of operand channels (rd1, rd2, imm by default)
- CTRL_W, 16, width of the control vector
- SE_MASK, 16'h0003, control bits forced to 0 whenever the output is a bubble or noop (bit0 MemWrite, bit1 RegWrite)
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  upstream holds a valid entry
- in_ready  out  1  block can accept an entry this cycle (registered)
- in_pc  in  DATA_W  PC of the upstream entry
- in_opnd  in  NUM_OPND*DATA_W  operand channels; channel k is at bits [k*DATA_W +: DATA_W]
- in_ctrl  in  CTRL_W  control vector
- in_noop  in  1  entry is a noop
- out_valid  out  1  downstream entry valid
- out_ready  in  1  downstream consumes this cycle
- out_pc  out  DATA_W  PC of the downstream entry
- out_opnd  out  NUM_OPND*DATA_W  operand channels
- out_ctrl  out  CTRL_W  control vector, masked
- out_noop  out  1  entry is a noop
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0
- bubble_cnt  out  CNT_W  cycles with out_valid=0 and out_ready=1

Behaviour:
- Storage: main slot M (drives outputs) and skid slot S, each holding a valid bit plus the payload {pc, opnd, ctrl, noop}.
- Reset (rst=0, asynchronous): both valids 0, all payload 0, both counters 0. Therefore out_valid=0, out_ctrl=0, out_pc=0, out_noop=0, and in_ready=1.
- in_ready = ~S.valid, taken directly from a flop.
- Transfers: acc = in_valid & in_ready; cons = out_valid & out_ready.
- Next state, evaluated in priority order at each rising edge:
  - flush=1: M.valid=0 and S.valid=0; any acc in this cycle is dropped; payload is don't-care. in_ready=1 on the next cycle.
  - M empty, or cons with S empty: if acc, load M from inputs; otherwise M.valid=0.
  - cons with S full: M takes S and S.valid=0. acc is impossible here because in_ready=0.
  - M full and no cons: if acc, load S from inputs. M holds.
- Latency: an entry accepted at edge N appears on the outputs after edge N, i.e. 1 cycle.
- Throughput: 1 entry/cycle while out_ready=1. No entry is ever lost or duplicated except by flush.
- Ordering is strict FIFO: S always holds an entry younger than M.
- out_ctrl = M.ctrl & ~SE_MASK whenever out_valid=0 or M.noop=1; otherwise M.ctrl.
- out_pc and out_opnd present M's payload unmasked even when M is invalid.
- Counters:
  - Sampled each cycle in which flush=0.
  - Each saturates at all-ones; no wrap.
  - Cycles with flush=1 count toward neither counter.
- Simultaneous events:
  - flush with cons: the consumed entry counts as delivered downstream; M and S still clear.
  - Full skid plus out_ready rising: S drains into M on the same edge; in_ready returns to 1 one cycle later.
- Reset asserted mid-transfer: state clears immediately, without waiting for a clock edge. Release is synchronised externally.

Decomposition:
- Shared package pipe_pkg holds:
  - control-bit index constants (CTRL_MEMWRITE=0, CTRL_REGWRITE=1, CTRL_MEMTOREG=2, CTRL_ALUSRC=3, CTRL_ALUOP=7:4, CTRL_LLB=8, CTRL_LHB=9)
  - the default SE_MASK
  - a payload width function: DATA_W*(1+NUM_OPND)+CTRL_W+1.
- One sub-module, pipe_slot: a valid flop plus a payload register with async active-low reset and a load enable. It is instantiated twice (M and S).
- Counters stay inline.

Test Plan:
- Reset then stream: hold rst=0 for 2 cycles, then present 4 entries with pc=16'h0000,0002,0004,0006 and out_ready=1. Required: out_valid=1 from the cycle after the first accept, the PCs emerge in order one per cycle, stall_cnt=0.
- Backpressure/skid: with M holding pc=16'h0010, drive out_ready=0 and present pc=16'h0012. Required: S fills and in_ready=0 on the next cycle. Raising out_ready then yields 0010 followed by 0012, with stall_cnt equal to the number of stalled cycles.
- Noop masking: present in_ctrl=16'h0033 with in_noop=1. Required: out_ctrl=16'h0030 and out_noop=1. The same ctrl with in_noop=0 gives out_ctrl=16'h0033.
- Flush priority: M and S both full, assert flush together with in_valid=1. Required: the next cycle shows out_valid=0, in_ready=1, out_ctrl & SE_MASK = 0, and the flushed and offered entries never appear.
- Counter saturation: with CNT_W=4, hold out_ready=1 and in_valid=0 for 20 cycles. Required: bubble_cnt stops at 4'hF.
- Async reset mid-stall: with M and S full, pull rst low between clock edges. Required: out_valid=0, in_ready=1 and both counters 0 immediately, before the next clock edge.
